// File: rtl/mem_wait_resp.sv
// ---------------------------------------------------------------------------
// mem_wait_resp
//
// Multi-cycle memory responder for the MIPS core's split instruction/data
// request interface. Instruction fetches and data loads/stores are served
// from one array of 2^AW 32-bit words. Each access takes LAT wait cycles.
// During those cycles the matching abort output stays high, which stalls
// the core.
//
// Parameters
//   N    data-path width of dataadr / writedata / readdata
//   AW   word-address bits (array holds 2^AW words)
//   LAT  wait cycles per access, 1..15
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   memwrite    store type: 00 none, 01 word, 11 doubleword, 10 no-op
//   datareq     data access request
//   dataadr     data byte address
//   writedata   store data
//   instradr    instruction byte address
//   instrreq    instruction fetch request
//   instr       fetched instruction
//   dataabort   1 = data access not complete, requester must hold
//   instrabort  1 = instruction fetch not complete, requester must hold
//   readdata    load data (even/odd word pair)
//   checkma     debug word address
//   checkm      debug read of word checkma (combinational)
// ---------------------------------------------------------------------------
module mem_wait_resp #(
  parameter int N   = 64,
  parameter int AW  = 8,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   memwrite,
  input  logic         datareq,
  input  logic [N-1:0] dataadr,
  input  logic [N-1:0] writedata,
  input  logic [31:0]  instradr,
  input  logic         instrreq,
  output logic [31:0]  instr,
  output logic         dataabort,
  output logic         instrabort,
  output logic [N-1:0] readdata,
  input  logic [7:0]   checkma,
  output logic [31:0]  checkm
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERV_D = 2'd1;
  localparam logic [1:0] SERV_I = 2'd2;

  // A request taken in IDLE counts from the acceptance cycle itself.
  // A request chained directly from the other service state counts from the
  // following cycle, so it needs one extra count to keep the same latency.
  localparam logic [3:0] CNT_FIRST = 4'(LAT - 1);
  localparam logic [3:0] CNT_CHAIN = 4'(LAT);

  logic [1:0]    state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] cadr_d, cadr_i;
  logic [N-1:0]  cwd;
  logic [1:0]    cmw;

  logic          cap_d, cap_i;
  logic          we;

  logic [31:0]   mem [2**AW];

  logic [AW-1:0] idx_d_in, idx_i_in;
  logic [AW-1:0] idx_even, idx_odd;
  logic [63:0]   wd64;

  assign idx_d_in = dataadr[AW+1:2];
  assign idx_i_in = instradr[AW+1:2];
  assign idx_even = {cadr_d[AW-1:1], 1'b0};
  assign idx_odd  = {cadr_d[AW-1:1], 1'b1};
  assign wd64     = 64'(cwd);

  // Address bits outside the word index are ignored by design.
  logic unused_adr;
  assign unused_adr = ^{dataadr[N-1:AW+2], dataadr[1:0],
                        instradr[31:AW+2], instradr[1:0]};

  // -------------------------------------------------------------------------
  // Next-state, abort and write-enable logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nx   = state;
    cnt_nx     = cnt;
    cap_d      = 1'b0;
    cap_i      = 1'b0;
    we         = 1'b0;
    dataabort  = datareq;
    instrabort = instrreq;

    case (state)
      IDLE: begin
        // Data wins over instruction fetch when both arrive together.
        if (datareq) begin
          cap_d    = 1'b1;
          cnt_nx   = CNT_FIRST;
          state_nx = SERV_D;
        end else if (instrreq) begin
          cap_i    = 1'b1;
          cnt_nx   = CNT_FIRST;
          state_nx = SERV_I;
        end
      end

      SERV_D: begin
        dataabort = (cnt != 4'd0);
        if (!datareq) begin
          // Requester withdrew: abandon the access, nothing is written.
          cnt_nx   = 4'd0;
          state_nx = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          // Completion cycle. memwrite 01 and 11 both have bit 0 set;
          // 10 is a no-op store.
          we = cmw[0];
          if (instrreq) begin
            cap_i    = 1'b1;
            cnt_nx   = CNT_CHAIN;
            state_nx = SERV_I;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      SERV_I: begin
        instrabort = (cnt != 4'd0);
        if (!instrreq) begin
          cnt_nx   = 4'd0;
          state_nx = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else if (datareq) begin
          cap_d    = 1'b1;
          cnt_nx   = CNT_CHAIN;
          state_nx = SERV_D;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counter and captured request registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      cadr_d <= '0;
      cadr_i <= '0;
      cwd    <= '0;
      cmw    <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap_d) begin
        cadr_d <= idx_d_in;
        cwd    <= writedata;
        cmw    <= memwrite;
      end
      if (cap_i) begin
        cadr_i <= idx_i_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset on purpose. Its contents must survive a
  // core reset. A store caught by reset is still dropped, because reset
  // forces IDLE and that clears the write enable.
  always_ff @(posedge clk) begin
    if (we) begin
      if (cmw[1]) begin
        mem[idx_even] <= wd64[31:0];
        mem[idx_odd]  <= wd64[63:32];
      end else begin
        mem[cadr_d]   <= wd64[31:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read paths (continuous; meaningful only when request=1 and abort=0)
  // -------------------------------------------------------------------------
  generate
    if (N >= 64) begin : g_dw_read
      assign readdata = N'({mem[idx_odd], mem[idx_even]});
    end else begin : g_w_read
      assign readdata = N'(mem[cadr_d]);
    end
  endgenerate

  assign instr = mem[cadr_i];

  // The debug read sees the old word during a write cycle; the new value
  // appears after the edge.
  assign checkm = mem[AW'(checkma)];

endmodule

// File: tb/tb_mem_wait_resp.sv
// ---------------------------------------------------------------------------
// tb_mem_wait_resp
//
// Directed bench for mem_wait_resp (N=64, AW=8, LAT=3). A table of data
// transactions fills and reads back the array. Hand-written sequences then
// cover data/instruction arbitration, cancellation and reset during a store.
// ---------------------------------------------------------------------------
module tb_mem_wait_resp;

  localparam int N   = 64;
  localparam int AW  = 8;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   memwrite;
  logic         datareq;
  logic [N-1:0] dataadr;
  logic [N-1:0] writedata;
  logic [31:0]  instradr;
  logic         instrreq;
  logic [31:0]  instr;
  logic         dataabort;
  logic         instrabort;
  logic [N-1:0] readdata;
  logic [7:0]   checkma;
  logic [31:0]  checkm;

  int n_cmp = 0;
  int n_err = 0;

  mem_wait_resp #(.N(N), .AW(AW), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .datareq    (datareq),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .instradr   (instradr),
    .instrreq   (instrreq),
    .instr      (instr),
    .dataabort  (dataabort),
    .instrabort (instrabort),
    .readdata   (readdata),
    .checkma    (checkma),
    .checkm     (checkm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mw;
    logic [63:0] adr;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic [63:0] rd_mask;  // 0 = readdata not checked
    logic [7:0]  cma;
    logic [31:0] exp_cm;   // checkm at cma after the access
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One data access. Starts #1 after a rising edge, counts abort cycles,
  // checks latency and (masked) readdata in the completion cycle, and
  // optionally the debug port's pre-write value. Returns #1 after the edge
  // that closes the completion cycle, with the request dropped.
  task automatic do_data(input string tag, input logic [1:0] mw,
                         input logic [63:0] adr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic [63:0] mask,
                         input bit chk_pre, input logic [31:0] pre_val);
    int  cycles = 0;
    bit  done   = 0;
    memwrite  = mw;
    dataadr   = adr;
    writedata = wd;
    datareq   = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!dataabort) done = 1;
      else begin
        cycles++;
        @(posedge clk); #1;
      end
    end
    check($sformatf("%s latency", tag), 64'(cycles), 64'(LAT));
    if (mask != 64'd0)
      check($sformatf("%s readdata", tag), readdata & mask, exp_rd & mask);
    if (chk_pre)
      check($sformatf("%s checkm before edge", tag), 64'(checkm), 64'(pre_val));
    @(posedge clk); #1;
    datareq  = 1'b0;
    memwrite = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int  d_at, i_at, cycles;
    bit  d_seen, i_seen;
    logic ia_at_dcomp;

    vecs[0]  = '{2'b01, 64'h10, 64'h0000_0000_2222_2222, 64'h0, 64'h0, 8'd4, 32'h2222_2222};
    vecs[1]  = '{2'b01, 64'h14, 64'hFFFF_0000_1111_1111, 64'h0, 64'h0, 8'd5, 32'h1111_1111};
    vecs[2]  = '{2'b00, 64'h10, 64'h0, 64'h1111_1111_2222_2222, '1, 8'd4, 32'h2222_2222};
    vecs[3]  = '{2'b01, 64'h20, 64'h0000_0000_DEAD_BEEF, 64'h0, 64'h0, 8'd8, 32'hDEAD_BEEF};
    vecs[4]  = '{2'b00, 64'h20, 64'h0, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_FFFF_FFFF, 8'd8, 32'hDEAD_BEEF};
    vecs[5]  = '{2'b01, 64'h24, 64'hFFFF_FFFF_1357_9BDF, 64'h0, 64'h0, 8'd9, 32'h1357_9BDF};
    vecs[6]  = '{2'b00, 64'h20, 64'h0, 64'h1357_9BDF_DEAD_BEEF, '1, 8'd9, 32'h1357_9BDF};
    vecs[7]  = '{2'b11, 64'h40, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 64'h0, 8'd16, 32'hCCCC_DDDD};
    vecs[8]  = '{2'b00, 64'h44, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, '1, 8'd17, 32'hAAAA_BBBB};
    vecs[9]  = '{2'b11, 64'h44, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 8'd16, 32'h89AB_CDEF};
    vecs[10] = '{2'b00, 64'hFFFF_FFFF_FFFF_FC40, 64'h0, 64'h0123_4567_89AB_CDEF, '1, 8'd17, 32'h0123_4567};
    vecs[11] = '{2'b10, 64'h40, '1, 64'h0123_4567_89AB_CDEF, '1, 8'd16, 32'h89AB_CDEF};
    vecs[12] = '{2'b01, 64'h3FC, 64'h0000_0000_CAFE_F00D, 64'h0, 64'h0, 8'd255, 32'hCAFE_F00D};
    vecs[13] = '{2'b00, 64'h3F8, 64'h0, 64'hCAFE_F00D_0000_0000, 64'hFFFF_FFFF_0000_0000, 8'd255, 32'hCAFE_F00D};
    vecs[14] = '{2'b11, 64'h0, 64'hB0B0_B0B0_A0A0_A0A0, 64'h0, 64'h0, 8'd0, 32'hA0A0_A0A0};
    vecs[15] = '{2'b01, 64'hC0, 64'h0000_0000_8C01_0004, 64'h0, 64'h0, 8'd48, 32'h8C01_0004};
    vecs[16] = '{2'b01, 64'h50, 64'h0000_0000_1234_5678, 64'h0, 64'h0, 8'd20, 32'h1234_5678};
    vecs[17] = '{2'b01, 64'h60, 64'h0000_0000_0BAD_F00D, 64'h0, 64'h0, 8'd24, 32'h0BAD_F00D};

    reset     = 1'b0;
    memwrite  = 2'b00;
    datareq   = 1'b0;
    dataadr   = '0;
    writedata = '0;
    instradr  = '0;
    instrreq  = 1'b0;
    checkma   = '0;

    // Reset state: aborts follow their requests.
    repeat (2) @(posedge clk);
    #1;
    check("reset dataabort idle", 64'(dataabort), 64'd0);
    check("reset instrabort idle", 64'(instrabort), 64'd0);
    datareq = 1'b1;
    #1;
    check("reset dataabort follows req", 64'(dataabort), 64'd1);
    datareq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven data transactions.
    for (int i = 0; i < 18; i++) begin
      do_data($sformatf("v%0d", i), vecs[i].mw, vecs[i].adr, vecs[i].wd,
              vecs[i].exp_rd, vecs[i].rd_mask, 1'b0, 32'h0);
      checkma = vecs[i].cma;
      #1;
      check($sformatf("v%0d checkm", i), 64'(checkm), 64'(vecs[i].exp_cm));
    end

    // Simultaneous data + instruction requests: data first (T+3),
    // instruction chained after it (T+7).
    datareq  = 1'b1;
    memwrite = 2'b00;
    dataadr  = 64'h10;
    instrreq = 1'b1;
    instradr = 32'hC0;
    d_seen = 0; i_seen = 0; d_at = -1; i_at = -1; ia_at_dcomp = 1'b0;
    for (int c = 0; c < 20 && !(d_seen && i_seen); c++) begin
      @(negedge clk);
      if (!d_seen && datareq && !dataabort) begin
        d_seen = 1;
        d_at = c;
        ia_at_dcomp = instrabort;
        check("arb readdata", readdata, 64'h1111_1111_2222_2222);
      end
      if (!i_seen && instrreq && !instrabort) begin
        i_seen = 1;
        i_at = c;
        check("arb instr", 64'(instr), 64'h8C01_0004);
      end
      @(posedge clk); #1;
      if (d_seen) datareq = 1'b0;
      if (i_seen) instrreq = 1'b0;
    end
    datareq  = 1'b0;
    instrreq = 1'b0;
    check("arb data done cycle", 64'(d_at), 64'd3);
    check("arb instr done cycle", 64'(i_at), 64'd7);
    check("arb instrabort during data done", 64'(ia_at_dcomp), 64'd1);

    // Lone instruction fetch; byte-offset and upper address bits ignored.
    instrreq = 1'b1;
    instradr = 32'hFFFF_FCC3;
    cycles = 0; i_seen = 0;
    for (int k = 0; k < 40 && !i_seen; k++) begin
      @(negedge clk);
      if (!instrabort) i_seen = 1;
      else begin
        cycles++;
        @(posedge clk); #1;
      end
    end
    check("ifetch latency", 64'(cycles), 64'(LAT));
    check("ifetch instr", 64'(instr), 64'h8C01_0004);
    @(posedge clk); #1;
    instrreq = 1'b0;

    // Cancellation: store withdrawn after one abort cycle leaves memory alone.
    memwrite  = 2'b01;
    dataadr   = 64'h50;
    writedata = 64'h5555_5555;
    datareq   = 1'b1;
    @(negedge clk);
    check("cancel abort in accept cycle", 64'(dataabort), 64'd1);
    @(posedge clk); #1;
    datareq  = 1'b0;
    memwrite = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkma = 8'd20;
    #1;
    check("cancel word unchanged", 64'(checkm), 64'h1234_5678);
    do_data("cancel reload", 2'b00, 64'h50, 64'h0, 64'h1234_5678,
            64'h0000_0000_FFFF_FFFF, 1'b0, 32'h0);

    // Debug read of a word in its own write cycle shows the old value.
    checkma = 8'd20;
    do_data("dbg store", 2'b01, 64'h50, 64'h9ABC_DEF0, 64'h0, 64'h0,
            1'b1, 32'h1234_5678);
    #1;
    check("dbg checkm after edge", 64'(checkm), 64'h9ABC_DEF0);

    // Reset in the 2nd wait cycle of a store.
    memwrite  = 2'b01;
    dataadr   = 64'h60;
    writedata = 64'h7777_7777;
    datareq   = 1'b1;
    @(posedge clk); #1;   // 1st wait cycle
    @(posedge clk); #1;   // 2nd wait cycle
    reset = 1'b0;
    #1;
    check("rst dataabort=datareq(1)", 64'(dataabort), 64'd1);
    check("rst instrabort=instrreq(0)", 64'(instrabort), 64'd0);
    check("rst readdata index 0", readdata, 64'hB0B0_B0B0_A0A0_A0A0);
    check("rst instr index 0", 64'(instr), 64'hA0A0_A0A0);
    instrreq = 1'b1;
    datareq  = 1'b0;
    #1;
    check("rst instrabort=instrreq(1)", 64'(instrabort), 64'd1);
    check("rst dataabort=datareq(0)", 64'(dataabort), 64'd0);
    instrreq = 1'b0;
    datareq  = 1'b1;
    @(posedge clk); #1;
    datareq  = 1'b0;
    memwrite = 2'b00;
    reset    = 1'b1;
    @(posedge clk); #1;
    checkma = 8'd24;
    #1;
    check("rst store dropped", 64'(checkm), 64'h0BAD_F00D);
    do_data("rst retry", 2'b01, 64'h60, 64'h7777_7777, 64'h0, 64'h0,
            1'b0, 32'h0);
    #1;
    check("rst retry committed", 64'(checkm), 64'h7777_7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
